// File: rtl/servo_pwm_4ch.sv
// Four-channel hobby-servo PWM generator with a shared frame counter.
// Define SERVO_SLEW_EN to limit the applied-angle change per frame to SLEW_DEG.
module servo_pwm_4ch #(
    parameter int FRAME_TICKS = 1000000,
    parameter int MIN_TICKS   = 25000,
    parameter int DEG_TICKS   = 556,
    parameter int SLEW_DEG    = 2,
    parameter int CNT_W       = $clog2(FRAME_TICKS)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] angle1,
    input  logic [7:0] angle2,
    input  logic [7:0] angle3,
    input  logic [7:0] angle4,
    output logic       pwm1,
    output logic       pwm2,
    output logic       pwm3,
    output logic       pwm4,
    output logic       frame_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [7:0]       MAX_DEG  = 8'd180;

    // The widest pulse must end before the frame does.
    if (MIN_TICKS + 180 * DEG_TICKS >= FRAME_TICKS) begin : g_bad_timing
        $fatal(1, "servo_pwm_4ch: MIN_TICKS + 180*DEG_TICKS must be below FRAME_TICKS");
    end
    if (SLEW_DEG < 0) begin : g_bad_slew
        $fatal(1, "servo_pwm_4ch: SLEW_DEG must not be negative");
    end

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             sample;
    logic [7:0]       angle_vec [4];
    logic [3:0]       pwm_vec;

    assign angle_vec[0] = angle1;
    assign angle_vec[1] = angle2;
    assign angle_vec[2] = angle3;
    assign angle_vec[3] = angle4;

    assign sample     = enable && (cnt_reg == CNT_LAST);
    assign frame_tick = enable && (cnt_reg == '0);

    // Parking at the last count makes the first enabled edge a sample edge.
    always_comb begin
        cnt_next = CNT_LAST;
        if (enable) begin
            cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= CNT_LAST;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [7:0]       target;
        logic [7:0]       cur_reg;
        logic [7:0]       cur_next;
        logic [CNT_W-1:0] width_reg;
        logic [CNT_W-1:0] width_next;
        logic             pwm_reg;

        assign target = (angle_vec[gi] > MAX_DEG) ? MAX_DEG : angle_vec[gi];

`ifdef SERVO_SLEW_EN
        localparam logic [7:0] STEP = (SLEW_DEG > 180) ? 8'd180 : 8'(SLEW_DEG);
        logic [7:0] up_gap;
        logic [7:0] dn_gap;

        always_comb begin
            up_gap   = target - cur_reg;
            dn_gap   = cur_reg - target;
            cur_next = cur_reg;
            if (target > cur_reg) begin
                cur_next = cur_reg + ((up_gap > STEP) ? STEP : up_gap);
            end else if (target < cur_reg) begin
                cur_next = cur_reg - ((dn_gap > STEP) ? STEP : dn_gap);
            end
        end
`else
        assign cur_next = target;
`endif

        assign width_next = CNT_W'(MIN_TICKS) + CNT_W'(cur_next) * CNT_W'(DEG_TICKS);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cur_reg   <= '0;
                width_reg <= CNT_W'(MIN_TICKS);
                pwm_reg   <= 1'b0;
            end else begin
                if (sample) begin
                    cur_reg   <= cur_next;
                    width_reg <= width_next;
                end
                pwm_reg <= enable && (cnt_reg < width_reg);
            end
        end

        assign pwm_vec[gi] = pwm_reg;
    end

    assign pwm1 = pwm_vec[0];
    assign pwm2 = pwm_vec[1];
    assign pwm3 = pwm_vec[2];
    assign pwm4 = pwm_vec[3];

endmodule

// File: tb/tb_servo_pwm_4ch.sv
// Bench for servo_pwm_4ch: measures frame period and pulse widths against an angle-level model.
module tb_servo_pwm_4ch;

    localparam int FT   = 2000;
    localparam int MINT = 100;
    localparam int DEGT = 5;
    localparam int SLEW = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] ang [4];
    logic       pwm1, pwm2, pwm3, pwm4;
    logic       frame_tick;
    logic [3:0] pwm_v;

    int tests  = 0;
    int fails  = 0;
    int frames = 0;
    int mdl_cur [4];

    assign pwm_v = {pwm4, pwm3, pwm2, pwm1};

    servo_pwm_4ch #(
        .FRAME_TICKS(FT),
        .MIN_TICKS  (MINT),
        .DEG_TICKS  (DEGT),
        .SLEW_DEG   (SLEW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .angle1    (ang[0]),
        .angle2    (ang[1]),
        .angle3    (ang[2]),
        .angle4    (ang[3]),
        .pwm1      (pwm1),
        .pwm2      (pwm2),
        .pwm3      (pwm3),
        .pwm4      (pwm4),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Applied angle after one sample edge, from the clamp and slew rules.
    task automatic model_sample();
        int tgt;
        for (int c = 0; c < 4; c++) begin
            tgt = (int'(ang[c]) > 180) ? 180 : int'(ang[c]);
`ifdef SERVO_SLEW_EN
            if (tgt > mdl_cur[c] + SLEW)      mdl_cur[c] = mdl_cur[c] + SLEW;
            else if (tgt < mdl_cur[c] - SLEW) mdl_cur[c] = mdl_cur[c] - SLEW;
            else                              mdl_cur[c] = tgt;
`else
            mdl_cur[c] = tgt;
`endif
        end
    endtask

    function automatic int exp_width(input int c);
        return MINT + mdl_cur[c] * DEGT;
    endfunction

    // Waits for the next frame_tick, then measures every channel over the frame.
    task automatic measure_frame(input int chg_at, input logic [7:0] chg_val);
        int waited;
        int hi [4];
        int rise [4];
        int extra;
        waited = 0;
        while (frame_tick !== 1'b1 && waited < FT + 10) begin
            @(negedge clk);
            waited++;
        end
        chk("tick_wait", waited, 1);
        chk("pwm_low_at_tick", int'(pwm_v), 0);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            hi[c]   = 0;
            rise[c] = 0;
        end
        for (int i = 1; i < FT; i++) begin
            @(negedge clk);
            if (i == chg_at) ang[0] = chg_val;
            if (frame_tick === 1'b1) extra++;
            for (int c = 0; c < 4; c++) begin
                if (pwm_v[c] === 1'b1) begin
                    hi[c]++;
                    if (rise[c] == 0) rise[c] = i;
                end
            end
        end
        frames++;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("width_ch%0d", c + 1), hi[c], exp_width(c));
            chk($sformatf("rise_ch%0d", c + 1), rise[c], 1);
        end
        chk("tick_once_per_frame", extra, 0);
        $display("[TB] frame %0d widths %0d %0d %0d %0d (want %0d %0d %0d %0d)",
                 frames, hi[0], hi[1], hi[2], hi[3],
                 exp_width(0), exp_width(1), exp_width(2), exp_width(3));
    endtask

    initial begin
        int viol;
        rst    = 1'b1;
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ang[c]     = 8'd0;
            mdl_cur[c] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_pwm", int'(pwm_v), 0);
        chk("reset_tick", int'(frame_tick), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_tick", int'(frame_tick), 0);
        chk("idle_pwm", int'(pwm_v), 0);

        // All angles zero: minimum pulses, period FT.
        enable = 1'b1;
        model_sample();
        measure_frame(0, 8'd0);
        model_sample();
        measure_frame(0, 8'd0);

        // Mixed angles, then an out-of-range angle that must clamp.
        ang[0] = 8'd90; ang[1] = 8'd180; ang[2] = 8'd45; ang[3] = 8'd0;
        model_sample();
        measure_frame(0, 8'd0);
        ang[0] = 8'd200;
        model_sample();
        measure_frame(0, 8'd0);

        // Mid-frame change is ignored until the next sample edge.
        ang[0] = 8'd0;
        model_sample();
        measure_frame(500, 8'd90);
        model_sample();
        measure_frame(0, 8'd0);

        // Asynchronous reset mid-pulse, then a ramp from 0 to 180 on channel 1.
        @(negedge clk);
        chk("tick_before_rst", int'(frame_tick), 1);
        repeat (50) @(negedge clk);
        chk("pwm1_mid_pulse", int'(pwm1), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_pwm", int'(pwm_v), 0);
        ang[0] = 8'd180;
        for (int c = 1; c < 4; c++) ang[c] = 8'($urandom_range(0, 255));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) mdl_cur[c] = 0;
        for (int f = 0; f < 19; f++) begin
            model_sample();
            measure_frame(0, 8'd0);
        end

        // Enable drop mid-pulse, idle period, then restart.
        @(negedge clk);
        chk("tick_before_disable", int'(frame_tick), 1);
        repeat (50) @(negedge clk);
        enable = 1'b0;
        #1;
        chk("disable_tick", int'(frame_tick), 0);
        @(negedge clk);
        chk("disable_pwm", int'(pwm_v), 0);
        for (int c = 0; c < 4; c++) ang[c] = 8'($urandom_range(0, 255));
        viol = 0;
        for (int i = 0; i < FT; i++) begin
            @(negedge clk);
            if (frame_tick !== 1'b0 || pwm_v !== 4'b0000) viol++;
        end
        chk("idle_outputs_quiet", viol, 0);
        enable = 1'b1;
        model_sample();
        measure_frame(0, 8'd0);

        // Random angles including out-of-range values.
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 4; c++) ang[c] = 8'($urandom_range(0, 255));
            model_sample();
            measure_frame(0, 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
